pipe_hazard_ctrl: RTL and testbench

Hazard and control-flow sequencer for the four-stage pipeline (IF, ID, EXMEM, WB). It drives the enable, flush and bubble controls of the IF_ID, ID_EXMEM and EXMEM_WB buffers and the PC write and redirect selects:
- stalls ID on read-after-write hazards;
- squashes wrong-path instructions when a jump or branch resolves taken in WB;
- fills the pipeline with bubbles after reset, because the buffers themselves have no reset.

It also keeps saturating stall and flush event counters.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/hazard_cmp.sv | 17 +
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipeline hazard/control-flow sequencer.
package pipe_pkg;

  localparam int REG_W = 6;
  localparam int OPC_W = 4;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  function automatic logic branch_taken(input logic jump, input logic branch_z,
                                        input logic branch_n, input logic z,
                                        input logic n);
    return jump | (branch_z & z) | (branch_n & n);
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Source/destination comparator: flags when an older instruction writes a
// register that the ID-stage instruction actually reads.
module hazard_cmp
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             reg_write,
  output logic             hit
);

  assign hit = reg_write & ((use_rs1 & (rs1 == rd)) | (use_rs2 & (rs2 == rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and control-flow sequencer for the IF/ID/EXMEM/WB pipeline: RAW stalls,
// WB-resolved redirects with squash, post-reset bubble fill, event counters.
//
// state | meaning
// FILL  | after reset, push bubbles through buffers that have no reset
// RUN   | normal flow
// STALL | previous cycle held ID on a RAW hazard
// FLUSH | squashing wrong-path fetches after a redirect
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int WB_BYPASS    = 0,
  parameter int FLUSH_CYCLES = 1,
  parameter int FILL_CYCLES  = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regWrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regWrite,
  input  logic             wb_jump,
  input  logic             wb_branchZ,
  input  logic             wb_branchN,
  input  logic             wb_Z,
  input  logic             wb_N,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_wb_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] FILL_INIT  = 3'(FILL_CYCLES - 1);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_e           st;
  logic [2:0]       remain;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic hz_ex, hz_wb_raw, hz_wb, hazard, take;
  logic in_run, do_redirect, do_stall;

  hazard_cmp u_cmp_ex (
    .rs1       (id_rs1),
    .rs2       (id_rs2),
    .use_rs1   (id_use_rs1),
    .use_rs2   (id_use_rs2),
    .rd        (ex_rd),
    .reg_write (ex_regWrite),
    .hit       (hz_ex)
  );

  hazard_cmp u_cmp_wb (
    .rs1       (id_rs1),
    .rs2       (id_rs2),
    .use_rs1   (id_use_rs1),
    .use_rs2   (id_use_rs2),
    .rd        (wb_rd),
    .reg_write (wb_regWrite),
    .hit       (hz_wb_raw)
  );

  assign hz_wb       = (WB_BYPASS != 0) ? 1'b0 : hz_wb_raw;
  assign hazard      = id_valid & (hz_ex | hz_wb);
  assign take        = branch_taken(wb_jump, wb_branchZ, wb_branchN, wb_Z, wb_N);
  assign in_run      = (st == S_RUN) || (st == S_STALL);
  assign do_redirect = in_run & take;
  assign do_stall    = in_run & hazard & ~take;

  always_comb begin
    pc_write     = 1'b1;
    pc_sel       = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_wb_flush  = 1'b0;
    if (!rst_n || st == S_FILL || st == S_FLUSH) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_wb_flush  = 1'b1;
    end else if (take) begin
      pc_sel       = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_wb_flush  = 1'b1;
    end else if (hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Reset is visible on the outputs immediately, before the first falling edge.
  assign state     = rst_n ? st : 2'b00;
  assign stall_cnt = rst_n ? stall_q : '0;
  assign flush_cnt = rst_n ? flush_q : '0;

  // Pipeline buffers load on the falling edge, so this sequencer does too.
  always_ff @(negedge clk) begin
    if (!rst_n) begin
      st      <= S_FILL;
      remain  <= FILL_INIT;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      case (st)
        S_FILL: begin
          if (remain == 3'd0) st <= S_RUN;
          else                remain <= remain - 3'd1;
        end
        S_FLUSH: begin
          // Entry value counts remaining squash cycles beyond the redirect cycle.
          if (remain <= 3'd1) st <= S_RUN;
          else                remain <= remain - 3'd1;
        end
        default: begin
          if (take) begin
            if (FLUSH_INIT == 3'd0) st <= S_RUN;
            else begin
              st     <= S_FLUSH;
              remain <= FLUSH_INIT;
            end
          end else if (hazard) st <= S_STALL;
          else                  st <= S_RUN;
        end
      endcase

      if (cnt_clr)                       stall_q <= '0;
      else if (do_stall && ~&stall_q)    stall_q <= stall_q + 1'b1;

      if (cnt_clr)                       flush_q <= '0;
      else if (do_redirect && ~&flush_q) flush_q <= flush_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: dut0 (no WB bypass, 2 flush cycles, 4-bit counters) and
// dut1 (WB bypass, 1 flush cycle, 16-bit counters) share the same inputs.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b1;
  logic rst_n;
  logic id_valid, id_use_rs1, id_use_rs2, ex_regWrite, wb_regWrite;
  logic [5:0] id_rs1, id_rs2, ex_rd, wb_rd;
  logic wb_jump, wb_branchZ, wb_branchN, wb_Z, wb_N, cnt_clr;

  logic pc_write0, pc_sel0, if_id_write0, if_id_flush0, id_ex_bubble0, ex_wb_flush0;
  logic [1:0] state0;
  logic [3:0] stall_cnt0, flush_cnt0;
  logic pc_write1, pc_sel1, if_id_write1, if_id_flush1, id_ex_bubble1, ex_wb_flush1;
  logic [1:0] state1;
  logic [15:0] stall_cnt1, flush_cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.WB_BYPASS(0), .FLUSH_CYCLES(2), .FILL_CYCLES(3), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_regWrite(ex_regWrite),
    .wb_rd(wb_rd), .wb_regWrite(wb_regWrite), .wb_jump(wb_jump), .wb_branchZ(wb_branchZ),
    .wb_branchN(wb_branchN), .wb_Z(wb_Z), .wb_N(wb_N), .cnt_clr(cnt_clr),
    .pc_write(pc_write0), .pc_sel(pc_sel0), .if_id_write(if_id_write0), .if_id_flush(if_id_flush0),
    .id_ex_bubble(id_ex_bubble0), .ex_wb_flush(ex_wb_flush0), .state(state0),
    .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0));

  pipe_hazard_ctrl #(.WB_BYPASS(1), .FLUSH_CYCLES(1), .FILL_CYCLES(3), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_regWrite(ex_regWrite),
    .wb_rd(wb_rd), .wb_regWrite(wb_regWrite), .wb_jump(wb_jump), .wb_branchZ(wb_branchZ),
    .wb_branchN(wb_branchN), .wb_Z(wb_Z), .wb_N(wb_N), .cnt_clr(cnt_clr),
    .pc_write(pc_write1), .pc_sel(pc_sel1), .if_id_write(if_id_write1), .if_id_flush(if_id_flush1),
    .id_ex_bubble(id_ex_bubble1), .ex_wb_flush(ex_wb_flush1), .state(state1),
    .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));

  // Advance to just after the next falling (active) edge; inputs change here.
  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic clr_in();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_rd = 0; ex_regWrite = 0; wb_rd = 0; wb_regWrite = 0;
    wb_jump = 0; wb_branchZ = 0; wb_branchN = 0; wb_Z = 0; wb_N = 0; cnt_clr = 0;
  endtask

  task automatic set_ex_hazard();
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 6'd5; ex_rd = 6'd5; ex_regWrite = 1;
  endtask

  task automatic test_reset();
    clr_in();
    rst_n = 0;
    tick();
    #1;
    n_tests++; if (state0 !== 2'd0) begin $display("FAIL rst_state got %0d exp 0", state0); n_fail++; end
    n_tests++; if (ex_wb_flush0 !== 1'b1 || pc_sel0 !== 1'b0) begin $display("FAIL rst_outs ex_wb_flush=%b pc_sel=%b exp 1 0", ex_wb_flush0, pc_sel0); n_fail++; end
    n_tests++; if (stall_cnt0 !== 4'd0 || flush_cnt1 !== 16'd0) begin $display("FAIL rst_cnt stall0=%0d flush1=%0d exp 0 0", stall_cnt0, flush_cnt1); n_fail++; end
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (ex_wb_flush0 !== 1'b1 || state0 !== 2'd0 || if_id_flush0 !== 1'b1) begin $display("FAIL fill_%0d ex_wb_flush=%b state=%0d exp 1 0", i, ex_wb_flush0, state0); n_fail++; end
      tick();
    end
    #1;
    n_tests++; if (state0 !== 2'd1 || ex_wb_flush0 !== 1'b0 || state1 !== 2'd1) begin $display("FAIL fill_done state0=%0d state1=%0d ex_wb_flush=%b exp 1 1 0", state0, state1, ex_wb_flush0); n_fail++; end
    n_tests++; if (stall_cnt0 !== 4'd0 || flush_cnt0 !== 4'd0) begin $display("FAIL fill_cnt stall=%0d flush=%0d exp 0 0", stall_cnt0, flush_cnt0); n_fail++; end
  endtask

  task automatic test_ex_hazard();
    set_ex_hazard();
    #1;
    n_tests++; if (pc_write0 !== 1'b0 || if_id_write0 !== 1'b0 || id_ex_bubble0 !== 1'b1) begin $display("FAIL ex_stall0 pc_write=%b if_id_write=%b bubble=%b exp 0 0 1", pc_write0, if_id_write0, id_ex_bubble0); n_fail++; end
    n_tests++; if (pc_write1 !== 1'b0 || ex_wb_flush1 !== 1'b0 || pc_sel1 !== 1'b0) begin $display("FAIL ex_stall1 pc_write=%b ex_wb_flush=%b pc_sel=%b exp 0 0 0", pc_write1, ex_wb_flush1, pc_sel1); n_fail++; end
    tick();
    clr_in();
    #1;
    n_tests++; if (stall_cnt0 !== 4'd1 || stall_cnt1 !== 16'd1) begin $display("FAIL ex_cnt stall0=%0d stall1=%0d exp 1 1", stall_cnt0, stall_cnt1); n_fail++; end
    n_tests++; if (state0 !== 2'd2 || pc_write0 !== 1'b1 || id_ex_bubble0 !== 1'b0) begin $display("FAIL ex_after state=%0d pc_write=%b bubble=%b exp 2 1 0", state0, pc_write0, id_ex_bubble0); n_fail++; end
    tick();
  endtask

  task automatic test_wb_hazard();
    id_valid = 1; id_use_rs2 = 1; id_rs2 = 6'd9; wb_rd = 6'd9; wb_regWrite = 1;
    #1;
    n_tests++; if (pc_write0 !== 1'b0 || id_ex_bubble0 !== 1'b0 + 1'b1) begin $display("FAIL wb_stall0 pc_write=%b bubble=%b exp 0 1", pc_write0, id_ex_bubble0); n_fail++; end
    n_tests++; if (pc_write1 !== 1'b1 || id_ex_bubble1 !== 1'b0) begin $display("FAIL wb_bypass1 pc_write=%b bubble=%b exp 1 0", pc_write1, id_ex_bubble1); n_fail++; end
    tick();
    clr_in();
    #1;
    n_tests++; if (stall_cnt0 !== 4'd2 || stall_cnt1 !== 16'd1) begin $display("FAIL wb_cnt stall0=%0d stall1=%0d exp 2 1", stall_cnt0, stall_cnt1); n_fail++; end
    tick();
  endtask

  task automatic test_branch_beats_stall();
    set_ex_hazard();
    wb_branchZ = 1; wb_Z = 1;
    #1;
    n_tests++; if (pc_sel0 !== 1'b1 || pc_write0 !== 1'b1 || if_id_flush0 !== 1'b1 || id_ex_bubble0 !== 1'b1 || ex_wb_flush0 !== 1'b1) begin $display("FAIL redir0 pc_sel=%b pc_write=%b flushes=%b%b%b exp 1 1 111", pc_sel0, pc_write0, if_id_flush0, id_ex_bubble0, ex_wb_flush0); n_fail++; end
    n_tests++; if (pc_sel1 !== 1'b1 || ex_wb_flush1 !== 1'b1) begin $display("FAIL redir1 pc_sel=%b ex_wb_flush=%b exp 1 1", pc_sel1, ex_wb_flush1); n_fail++; end
    tick();
    clr_in();
    wb_jump = 1;
    #1;
    n_tests++; if (state0 !== 2'd3 || pc_sel0 !== 1'b0 || pc_write0 !== 1'b1 || ex_wb_flush0 !== 1'b1) begin $display("FAIL flush0 state=%0d pc_sel=%b pc_write=%b ex_wb_flush=%b exp 3 0 1 1", state0, pc_sel0, pc_write0, ex_wb_flush0); n_fail++; end
    n_tests++; if (flush_cnt0 !== 4'd1 || stall_cnt0 !== 4'd2) begin $display("FAIL redir_cnt0 flush=%0d stall=%0d exp 1 2", flush_cnt0, stall_cnt0); n_fail++; end
    n_tests++; if (state1 !== 2'd1 || pc_sel1 !== 1'b1) begin $display("FAIL redir1_run state=%0d pc_sel=%b exp 1 1", state1, pc_sel1); n_fail++; end
    tick();
    clr_in();
    #1;
    n_tests++; if (state0 !== 2'd1 || flush_cnt0 !== 4'd1) begin $display("FAIL flush_end0 state=%0d flush=%0d exp 1 1", state0, flush_cnt0); n_fail++; end
    n_tests++; if (flush_cnt1 !== 16'd2 || stall_cnt1 !== 16'd1) begin $display("FAIL flush_end1 flush=%0d stall=%0d exp 2 1", flush_cnt1, stall_cnt1); n_fail++; end
  endtask

  task automatic test_not_taken();
    wb_branchN = 1; wb_N = 0; wb_branchZ = 1; wb_Z = 0;
    id_use_rs1 = 1; id_rs1 = 6'd5; ex_rd = 6'd5; ex_regWrite = 1; id_valid = 0;
    #1;
    n_tests++; if (pc_sel0 !== 1'b0 || ex_wb_flush0 !== 1'b0 || if_id_flush0 !== 1'b0 || pc_write0 !== 1'b1) begin $display("FAIL not_taken pc_sel=%b ex_wb_flush=%b if_id_flush=%b pc_write=%b exp 0 0 0 1", pc_sel0, ex_wb_flush0, if_id_flush0, pc_write0); n_fail++; end
    tick();
    clr_in();
    #1;
    n_tests++; if (flush_cnt0 !== 4'd1 || stall_cnt0 !== 4'd2 || state0 !== 2'd1) begin $display("FAIL not_taken_cnt flush=%0d stall=%0d state=%0d exp 1 2 1", flush_cnt0, stall_cnt0, state0); n_fail++; end
  endtask

  task automatic test_saturation();
    set_ex_hazard();
    for (int i = 0; i < 20; i++) tick();
    #1;
    n_tests++; if (stall_cnt0 !== 4'd15 || stall_cnt1 !== 16'd21) begin $display("FAIL sat stall0=%0d stall1=%0d exp 15 21", stall_cnt0, stall_cnt1); n_fail++; end
    cnt_clr = 1;
    tick();
    clr_in();
    #1;
    n_tests++; if (stall_cnt0 !== 4'd0 || stall_cnt1 !== 16'd0 || flush_cnt0 !== 4'd0 || flush_cnt1 !== 16'd0) begin $display("FAIL cnt_clr stall0=%0d stall1=%0d flush0=%0d flush1=%0d exp 0", stall_cnt0, stall_cnt1, flush_cnt0, flush_cnt1); n_fail++; end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    wb_jump = 1;
    tick();
    clr_in();
    rst_n = 0;
    #1;
    n_tests++; if (state0 !== 2'd0 || flush_cnt0 !== 4'd0 || pc_sel0 !== 1'b0) begin $display("FAIL rst_mid state=%0d flush=%0d pc_sel=%b exp 0 0 0", state0, flush_cnt0, pc_sel0); n_fail++; end
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) tick();
    #1;
    n_tests++; if (state0 !== 2'd1 || ex_wb_flush0 !== 1'b0 || flush_cnt0 !== 4'd0) begin $display("FAIL rst_mid_run state=%0d ex_wb_flush=%b flush=%0d exp 1 0 0", state0, ex_wb_flush0, flush_cnt0); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_ex_hazard();
    test_wb_hazard();
    test_branch_beats_stall();
    test_not_taken();
    test_saturation();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
